// File: rtl/frame_pkg.sv
// Shared types and constants for the framed byte sender.
// FRAME_SENDER_CHECKSUM_EN selects whether the CHK byte is part of the frame.
package frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_LEN,
    S_FUNC,
    S_PAYLOAD,
    S_CHK,
    S_TAIL
  } state_t;

  localparam logic [7:0] DEF_HEAD = 8'h52;
  localparam logic [7:0] DEF_TAIL = 8'h9A;
  localparam logic [7:0] DEF_FUNC = 8'h01;

  // Non-payload bytes in a frame: HEAD, LEN, FUNC, [CHK], TAIL.
`ifdef FRAME_SENDER_CHECKSUM_EN
  localparam int HDR_OVERHEAD = 5;
`else
  localparam int HDR_OVERHEAD = 4;
`endif

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for a bank of keys, sampled only on btn_en strobes.
// Each pulse lasts one cycle because the history catches up on the same strobe.
module key_edge_detect #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_en,
  input  logic [N-1:0] keys,
  output logic [N-1:0] pulses
);

  logic [N-1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
    end else if (btn_en) begin
      hist <= keys;
    end
  end

  assign pulses = btn_en ? (keys & ~hist) : '0;

endmodule

// File: rtl/frame_sender.sv
// Editable payload store plus a valid/ready framed byte streamer toward uart_tx.
// FRAME_SENDER_CHECKSUM_EN adds the CHK byte and its running-sum logic.
//
// state     | meaning
// S_IDLE    | waiting for a send edge, payload editable
// S_HEAD    | presenting FRAME_HEAD
// S_LEN     | presenting frame length
// S_FUNC    | presenting FUNC_CODE
// S_PAYLOAD | presenting ram[byte_cnt], PAYLOAD_LEN times
// S_CHK     | presenting latched checksum
// S_TAIL    | presenting FRAME_TAIL
module frame_sender
  import frame_pkg::*;
#(
  parameter int         PAYLOAD_LEN = 8,
  parameter logic [7:0] FRAME_HEAD  = DEF_HEAD,
  parameter logic [7:0] FRAME_TAIL  = DEF_TAIL,
  parameter logic [7:0] FUNC_CODE   = DEF_FUNC
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           btn_en,
  input  logic                           key_next,
  input  logic                           key_prev,
  input  logic                           key_inc,
  input  logic                           key_dec,
  input  logic                           key_send,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [7:0]                     preview_data,
  output logic [$clog2(PAYLOAD_LEN)-1:0] preview_index,
  output logic                           busy
);

  localparam int         IDX_W    = $clog2(PAYLOAD_LEN);
  localparam logic [7:0] LEN_BYTE = 8'(PAYLOAD_LEN + HDR_OVERHEAD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

  logic [4:0] pulses;
  logic p_next, p_prev, p_inc, p_dec, p_send;

  key_edge_detect #(.N(5)) u_keys (
    .clk    (clk),
    .rst    (rst),
    .btn_en (btn_en),
    .keys   ({key_send, key_dec, key_inc, key_prev, key_next}),
    .pulses (pulses)
  );

  assign {p_send, p_dec, p_inc, p_prev, p_next} = pulses;

  state_t           state, state_nx;
  logic [IDX_W-1:0] index, byte_cnt;
  logic [7:0]       ram [PAYLOAD_LEN];
  logic             start, edit_ok, fire;

  assign start = (state == S_IDLE) && p_send;
  // Edits are also blocked on the start cycle so the frame matches the latched checksum.
  assign edit_ok = (state == S_IDLE) && !p_send;
  assign fire    = tx_valid && tx_ready;
  assign busy    = (state != S_IDLE);
  assign preview_index = index;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index <= '0;
      for (int i = 0; i < PAYLOAD_LEN; i++) ram[i] <= '0;
    end else if (edit_ok) begin
      if (p_inc)      ram[index] <= ram[index] + 8'd1;
      else if (p_dec) ram[index] <= ram[index] - 8'd1;
      if (p_next)      index <= (index == LAST_IDX) ? '0 : index + 1'b1;
      else if (p_prev) index <= (index == '0) ? LAST_IDX : index - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) preview_data <= '0;
    else     preview_data <= ram[index];
  end

`ifdef FRAME_SENDER_CHECKSUM_EN
  localparam logic [7:0] FIXED_SUM = 8'(FRAME_HEAD + LEN_BYTE + FUNC_CODE + FRAME_TAIL);
  logic [7:0] pay_sum, chk_q;

  // Running payload sum tracks every edit, so no wide adder tree is needed at send time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pay_sum <= '0;
      chk_q   <= '0;
    end else begin
      if (edit_ok && p_inc)      pay_sum <= pay_sum + 8'd1;
      else if (edit_ok && p_dec) pay_sum <= pay_sum - 8'd1;
      if (start) chk_q <= ~(FIXED_SUM + pay_sum);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
    end else begin
      state <= state_nx;
      if (start)                             byte_cnt <= '0;
      else if (state == S_PAYLOAD && fire)   byte_cnt <= byte_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      S_IDLE: if (p_send) state_nx = S_HEAD;
      S_HEAD: begin
        tx_valid = 1'b1;
        tx_data  = FRAME_HEAD;
        if (tx_ready) state_nx = S_LEN;
      end
      S_LEN: begin
        tx_valid = 1'b1;
        tx_data  = LEN_BYTE;
        if (tx_ready) state_nx = S_FUNC;
      end
      S_FUNC: begin
        tx_valid = 1'b1;
        tx_data  = FUNC_CODE;
        if (tx_ready) state_nx = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = ram[byte_cnt];
`ifdef FRAME_SENDER_CHECKSUM_EN
        if (tx_ready && byte_cnt == LAST_IDX) state_nx = S_CHK;
`else
        if (tx_ready && byte_cnt == LAST_IDX) state_nx = S_TAIL;
`endif
      end
`ifdef FRAME_SENDER_CHECKSUM_EN
      S_CHK: begin
        tx_valid = 1'b1;
        tx_data  = chk_q;
        if (tx_ready) state_nx = S_TAIL;
      end
`endif
      S_TAIL: begin
        tx_valid = 1'b1;
        tx_data  = FRAME_TAIL;
        if (tx_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_sender.sv
// Scoreboard bench for frame_sender: stimulus pushes expected frame bytes,
// a negedge monitor pops them on every accepted byte and checks stall hold.
module tb_frame_sender;

  localparam int PLEN  = 8;
  localparam int IDX_W = $clog2(PLEN);
`ifdef FRAME_SENDER_CHECKSUM_EN
  localparam int FRAME_BYTES = PLEN + 5;
`else
  localparam int FRAME_BYTES = PLEN + 4;
`endif
  localparam logic [7:0] LEN_B = 8'(FRAME_BYTES);

  localparam logic [4:0] K_NEXT = 5'b00001;
  localparam logic [4:0] K_PREV = 5'b00010;
  localparam logic [4:0] K_INC  = 5'b00100;
  localparam logic [4:0] K_DEC  = 5'b01000;
  localparam logic [4:0] K_SEND = 5'b10000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             btn_en = 1'b1;
  logic [4:0]       keys = '0;
  logic             tx_ready = 1'b1;
  logic [7:0]       tx_data, preview_data;
  logic             tx_valid, busy;
  logic [IDX_W-1:0] preview_index;

  frame_sender #(.PAYLOAD_LEN(PLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_en        (btn_en),
    .key_next      (keys[0]),
    .key_prev      (keys[1]),
    .key_inc       (keys[2]),
    .key_dec       (keys[3]),
    .key_send      (keys[4]),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .preview_data  (preview_data),
    .preview_index (preview_index),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int         nchecks = 0;
  int         nerrors = 0;
  logic [7:0] expq[$];
  logic [7:0] model[PLEN];
  int         midx = 0;
  bit         stall_en = 0;
  int         busy_cycles = 0;
  int         rcyc = 0;
  int         pat[4] = '{1, 0, 0, 1};
  bit         hold_chk = 0;
  logic [7:0] held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame();
    logic [7:0] s;
    s = 8'h52 + LEN_B + 8'h01 + 8'h9A;
    expq.push_back(8'h52);
    expq.push_back(LEN_B);
    expq.push_back(8'h01);
    for (int i = 0; i < PLEN; i++) begin
      expq.push_back(model[i]);
      s = s + model[i];
    end
`ifdef FRAME_SENDER_CHECKSUM_EN
    expq.push_back(~s);
`endif
    expq.push_back(8'h9A);
  endtask

  task automatic press(input logic [4:0] mask);
    @(posedge clk);
    #1 keys = mask;
    @(posedge clk);
    #1 keys = '0;
  endtask

  task automatic press_edit(input logic [4:0] mask);
    press(mask);
    if (mask[2])      model[midx] = model[midx] + 8'd1;
    else if (mask[3]) model[midx] = model[midx] - 8'd1;
    if (mask[0])      midx = (midx + 1) % PLEN;
    else if (mask[1]) midx = (midx + PLEN - 1) % PLEN;
  endtask

  task automatic chk_preview(input string name);
    @(posedge clk);
    @(negedge clk);
    check({name, "_index"}, 32'(preview_index), 32'(midx));
    check({name, "_data"}, 32'(preview_data), 32'(model[midx]));
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!busy && expq.size() == 0) done = 1;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_valid_low"}, 32'(tx_valid), 32'd0);
  endtask

  // tx_ready driver: constant 1, or the 1-0-0-1 stall pattern.
  initial forever begin
    @(posedge clk);
    #1;
    if (stall_en) begin
      tx_ready = pat[rcyc % 4][0];
      rcyc++;
    end else begin
      tx_ready = 1'b1;
    end
  end

  // Monitor: compare every accepted byte, and hold-stability while stalled.
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    if (busy) busy_cycles++;
    if (!rst && hold_chk) check("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, held});
    hold_chk = tx_valid && !tx_ready;
    held = tx_data;
    if (tx_valid && tx_ready) begin
      if (expq.size() == 0) begin
        nchecks++;
        nerrors++;
        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
      end else begin
        e = expq.pop_front();
        check("tx_byte", 32'(tx_data), 32'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < PLEN; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_pdata", 32'(preview_data), 32'd0);
    check("rst_pindex", 32'(preview_index), 32'd0);

    // Default frame, back-to-back acceptance.
    push_frame();
    busy_cycles = 0;
    press(K_SEND);
    @(negedge clk);
    check("send_valid", 32'(tx_valid), 32'd1);
    check("send_busy", 32'(busy), 32'd1);
    check("send_head", 32'(tx_data), 32'h52);
    wait_done("frame1");
    check("busy_cycles", 32'(busy_cycles), 32'(FRAME_BYTES));

    // Three increments at index 0, then send.
    press_edit(K_INC);
    press_edit(K_INC);
    press_edit(K_INC);
    chk_preview("inc3");
    push_frame();
    press(K_SEND);
    wait_done("frame2");

    // Wrap and modular edits.
    press_edit(K_PREV);
    chk_preview("prev_wrap");
    press_edit(K_DEC);
    chk_preview("dec_wrap");
    press_edit(K_INC);
    chk_preview("inc_wrap");
    press_edit(K_NEXT);
    chk_preview("next_wrap");
    press_edit(K_NEXT | K_PREV);
    chk_preview("next_wins");
    press_edit(K_INC | K_DEC);
    chk_preview("inc_wins");
    press_edit(K_INC | K_PREV);
    chk_preview("edit_old_index");
    press_edit(K_NEXT);
    chk_preview("edit_then_move");

    // Key activity without btn_en must be invisible.
    btn_en = 1'b0;
    keys = K_INC | K_NEXT;
    repeat (3) @(posedge clk);
    #1 keys = '0;
    repeat (2) @(posedge clk);
    #1 btn_en = 1'b1;
    chk_preview("btn_gate");

    // Stalled frame: 1-0-0-1 ready pattern.
    stall_en = 1;
    push_frame();
    press(K_SEND);
    wait_done("frame_stall");
    stall_en = 0;

    // Keys pressed while busy are ignored.
    push_frame();
    press(K_SEND);
    press(K_INC);
    press(K_NEXT);
    press(K_SEND);
    wait_done("frame_locked");
    repeat (20) @(negedge clk);
    check("no_second_frame", 32'(busy), 32'd0);
    chk_preview("locked_payload");

    // Reset in the middle of the payload.
    press_edit(K_INC);
    push_frame();
    press(K_SEND);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    expq.delete();
    for (int i = 0; i < PLEN; i++) model[i] = 8'h00;
    midx = 0;
    #1;
    check("midrst_valid", 32'(tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pdata", 32'(preview_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_frame();
    press(K_SEND);
    @(negedge clk);
    check("after_rst_head", 32'(tx_data), 32'h52);
    wait_done("frame_after_rst");

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/frame_sender.md
Name: frame_sender

Overview:
Parametrised successor of the fixed 8-byte panel sender. It holds a PAYLOAD_LEN-byte editable payload, edited through five push keys, and streams a framed packet one byte at a time to the UART transmitter. The byte stream uses a valid/ready handshake. Frame layout: HEAD, LEN, FUNC, payload[0..N-1], CHK, TAIL. It sits between the key debouncer (which supplies btn_en) and uart_tx.

Parameters:
PAYLOAD_LEN, 8, number of payload bytes (2..64)
FRAME_HEAD, 8'h52, header byte
FRAME_TAIL, 8'h9A, tail byte
FUNC_CODE, 8'h01, function-code byte

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
btn_en  in  1  key sample strobe; key inputs and edge detectors update only when high
key_next  in  1  select next payload byte
key_prev  in  1  select previous payload byte
key_inc  in  1  increment selected byte
key_dec  in  1  decrement selected byte
key_send  in  1  start frame transmission
tx_data  out  8  current frame byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts byte
preview_data  out  8  value of the selected payload byte
preview_index  out  $clog2(PAYLOAD_LEN)  selected payload index
busy  out  1  frame in progress

Behaviour:
- Reset (async, rst=1):
  - index=0, all payload bytes 0, preview_data=0.
  - tx_valid=0, tx_data=0, busy=0, FSM=IDLE.
  - Key history registers cleared.
- Edge detection:
  - A rising edge is key && !key_prev, evaluated only on cycles with btn_en=1.
  - The history registers update only on btn_en cycles.
- Index selection:
  - next edge: index+1, wrapping from PAYLOAD_LEN-1 to 0.
  - prev edge: index-1, wrapping from 0 to PAYLOAD_LEN-1.
  - next and prev in the same cycle: next wins.
- Byte editing:
  - inc/dec edges change ram[index] by ±1 mod 256 (0xFF+1=0x00, 0x00-1=0xFF).
  - inc and dec in the same cycle: inc wins.
  - An edit and an index change in the same cycle: the edit applies to the old index, then the index moves.
- preview_data:
  - Registered; always equals ram[preview_index] one cycle after any change to either.
- Edit lock:
  - While busy=1, edit and index keys are ignored, so the payload is frozen during a frame.
  - Their edge history still updates.
- Send:
  - A send edge in IDLE latches the checksum and moves to HEAD.
  - tx_valid rises on the next cycle with tx_data=FRAME_HEAD; busy rises in the same cycle.
  - A send edge while busy is ignored, never queued.
- FSM states: IDLE -> HEAD -> LEN -> FUNC -> PAYLOAD -> CHK -> TAIL -> IDLE.
  - Every transition out of a byte state occurs only on tx_valid && tx_ready.
  - PAYLOAD repeats PAYLOAD_LEN times using an internal byte counter.
- Handshake:
  - tx_data is stable while tx_valid && !tx_ready.
  - tx_valid is never withdrawn before acceptance.
  - Back-to-back acceptance gives one byte per cycle.
  - After TAIL is accepted: tx_valid=0 and busy=0 in the next cycle.
- LEN byte: PAYLOAD_LEN+5, 8-bit.
- CHK byte: bitwise NOT of the 8-bit modular sum of HEAD, LEN, FUNC, all payload bytes and TAIL.
- Reset mid-frame: immediate return to IDLE, tx_valid=0, payload cleared.

Optional Feature:
- Macro: FRAME_SENDER_CHECKSUM_EN.
- Defined: behaviour as above, with CHK present and LEN=PAYLOAD_LEN+5.
- Undefined:
  - The CHK state and the checksum adder are removed.
  - The FSM goes PAYLOAD -> TAIL.
  - LEN=PAYLOAD_LEN+4.

Decomposition:
- Package frame_pkg:
  - FSM state enum (S_IDLE, S_HEAD, S_LEN, S_FUNC, S_PAYLOAD, S_CHK, S_TAIL).
  - Default HEAD/TAIL/FUNC constants.
  - Header overhead constant (5, or 4 without checksum).
- Sub-module key_edge_detect: parametrised key count, btn_en-gated history, one-cycle pulse outputs.

Test Plan:
1. Reset, then key_send edge (defaults) with tx_ready tied 1 -> bytes 52 0D 01 00×8 05 9A; busy high 13 cycles.
2. key_inc ×3 on index 0, then send -> payload[0]=03, CHK=02; preview_data=03 after the third edge.
3. At index 0 press key_prev -> preview_index=7; at 0x00 press key_dec -> byte=FF; key_inc -> 00.
4. tx_ready toggling 1-0-0-1 during the frame -> tx_data held while stalled; byte sequence identical to scenario 1; no byte skipped or duplicated.
5. key_inc and key_send pressed while busy -> payload unchanged, no second frame; rst asserted mid-PAYLOAD -> tx_valid=0 immediately, next frame starts from HEAD with payload 00.
6. Build without FRAME_SENDER_CHECKSUM_EN, PAYLOAD_LEN=4 -> bytes 52 08 01 00 00 00 00 9A.
